detect_uart_tx: RTL and testbench

DETECT_UART_TX -- requirements
Module: detect_uart_tx

---
 rtl/detect_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_detect_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_uart_tx.sv
// Serialises each accepted frame result as a 5-byte 8N1 UART packet, with a
// single-entry pending slot so back-to-back packets go out without an idle gap.
module detect_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [2:0]  direction,
    input  logic        orange_detected,
    input  logic [17:0] orange_count,
    output logic        uart_tx,
    output logic        busy,
    output logic        pkt_done,
    output logic [7:0]  dropped_count
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'd4;

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [21:0] active_q, active_d;
    logic [21:0] pending_q, pending_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  drop_q, drop_d;
    logic        done_q, done_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic [21:0] snap_in;
    logic [7:0]  cur_byte;
    logic        bit_end;

    // Snapshot layout: {direction[2:0], orange_detected, orange_count[17:0]}
    assign snap_in = {direction, orange_detected, orange_count};
    assign bit_end = (clk_cnt_q == BIT_LAST);

    function automatic logic [7:0] pkt_byte(input logic [21:0] s, input logic [2:0] idx);
        logic [7:0] st;
        st = {2'b00, s[17:16], s[18], s[21:19]};
        case (idx)
            3'd0:    pkt_byte = HEADER;
            3'd1:    pkt_byte = st;
            3'd2:    pkt_byte = s[15:8];
            3'd3:    pkt_byte = s[7:0];
            default: pkt_byte = st ^ s[15:8] ^ s[7:0];
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        cur_byte   = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 16'd1;
            if (frame_valid) begin
                pending_d  = snap_in;
                pend_vld_d = 1'b1;
                if (pend_vld_q && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    active_d   = snap_in;
                    state_d    = START;
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        done_d     = 1'b1;
                        byte_idx_d = '0;
                        // A frame arriving in this last cycle is promoted directly,
                        // as if it had passed through the pending slot.
                        if (frame_valid || pend_vld_q) begin
                            active_d   = frame_valid ? snap_in : pending_q;
                            pend_vld_d = 1'b0;
                            state_d    = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state to keep uart_tx glitch-free.
        cur_byte = pkt_byte(active_d, byte_idx_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            drop_q     <= '0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_tx       = tx_q;
    assign busy          = busy_q;
    assign pkt_done      = done_q;
    assign dropped_count = drop_q;

endmodule

// File: tb/tb_detect_uart_tx.sv
// Scoreboard bench for detect_uart_tx: stimulus queues hand-computed bytes,
// a serial receiver monitor pops and compares them along with pkt_done timing.
module tb_detect_uart_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic        frame_valid;
    logic [2:0]  direction;
    logic        orange_detected;
    logic [17:0] orange_count;
    logic        uart_tx;
    logic        busy;
    logic        pkt_done;
    logic [7:0]  dropped_count;

    detect_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hAA)) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_valid     (frame_valid),
        .direction       (direction),
        .orange_detected (orange_detected),
        .orange_count    (orange_count),
        .uart_tx         (uart_tx),
        .busy            (busy),
        .pkt_done        (pkt_done),
        .dropped_count   (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_pkt(input logic [39:0] v, input int n, input bit last_flag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.b    = v[39 - 8*i -: 8];
            e.last = last_flag && (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse(input logic [2:0] d, input logic det, input logic [17:0] c);
        @(posedge clk); #1;
        direction       = d;
        orange_detected = det;
        orange_count    = c;
        frame_valid     = 1'b1;
        @(posedge clk); #1;
        frame_valid     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pkt_done !== 1'b1 && n < limit);
        if (pkt_done !== 1'b1) check("pkt_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic check_idle(input string name);
        check({name, "_tx"},   32'(uart_tx), 32'(1));
        check({name, "_busy"}, 32'(busy),    32'(0));
    endtask

    // Serial receiver monitor
    int         ncyc = 0;
    int         done_due = 0;
    int         rc = 0;
    int         pstart = 0;
    int         bidx = 0;
    bit         rx_on = 1'b0;
    logic       fr_ok;
    logic [7:0] sh;

    always @(negedge clk) begin
        int bitn;
        int ph;
        ncyc++;
        if (pkt_done === 1'b1 || ncyc == done_due)
            check("pkt_done_timing", 32'(pkt_done), 32'(ncyc == done_due));
        if (reset === 1'b1) begin
            rx_on    = 1'b0;
            done_due = 0;
            bidx     = 0;
        end else begin
            if (!rx_on && uart_tx === 1'b0) begin
                rx_on = 1'b1;
                rc    = 0;
                fr_ok = 1'b1;
                if (bidx == 0) pstart = ncyc;
            end
            if (rx_on) begin
                bitn = rc / CPB;
                ph   = rc % CPB;
                if (bitn == 0)      fr_ok = fr_ok & (uart_tx === 1'b0);
                else if (bitn == 9) fr_ok = fr_ok & (uart_tx === 1'b1);
                else if (ph == 0)   sh[bitn-1] = uart_tx;
                else                fr_ok = fr_ok & (uart_tx === sh[bitn-1]);
                rc++;
                if (rc == 10*CPB) begin
                    rx_on = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rx_unexpected: got byte %0h, expected none at %0t", sh, $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rx_byte", 32'({fr_ok, sh}), 32'({1'b1, e.b}));
                        if (e.last) begin
                            done_due = ncyc + 1;
                            check("pkt_len", 32'(ncyc - pstart + 1), 32'(50*CPB));
                            bidx = 0;
                        end else begin
                            bidx++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  quiet;

        reset           = 1'b1;
        frame_valid     = 1'b1;
        direction       = '0;
        orange_detected = 1'b0;
        orange_count    = '0;

        // Reset with frame_valid held: must stay idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_done", 32'(pkt_done),      32'(0));
        check("reset_drop", 32'(dropped_count), 32'(0));
        @(posedge clk); #1;
        reset       = 1'b0;
        frame_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_idle("post_reset");

        // Basic packet: AA 2B 12 34 0D, 200 cycles, pkt_done at cycle 201
        push_pkt(40'hAA2B12340D, 5, 1'b1);
        pulse(3'b011, 1'b1, 18'h21234);
        @(negedge clk);
        check("start_tx",   32'(uart_tx), 32'(0));
        check("start_busy", 32'(busy),    32'(1));
        wait_done(400, n);
        check("done_latency", 32'(n + 1), 32'(201));
        check_idle("after_pkt");

        // Inputs toggled while busy do not disturb bytes in flight
        push_pkt(40'hAA0100FFFE, 5, 1'b1);
        pulse(3'b001, 1'b0, 18'h000FF);
        for (int i = 0; i < 190; i++) begin
            @(negedge clk); #1;
            direction       = 3'($urandom);
            orange_detected = 1'($urandom);
            orange_count    = 18'($urandom);
        end
        wait_done(100, n);
        check_idle("after_toggle");

        // Back-to-back: second packet starts on the pkt_done cycle
        push_pkt(40'hAA1AABCD7C, 5, 1'b1);
        push_pkt(40'hAA330F0F33, 5, 1'b1);
        pulse(3'b010, 1'b1, 18'h1ABCD);
        repeat (9) @(posedge clk);
        pulse(3'b011, 1'b0, 18'h30F0F);
        wait_done(400, n);
        check("b2b_tx",   32'(uart_tx),       32'(0));
        check("b2b_busy", 32'(busy),          32'(1));
        check("b2b_drop", 32'(dropped_count), 32'(0));
        wait_done(400, n);
        check_idle("after_b2b");

        // Three pulses in one packet: first and last sent, one drop
        push_pkt(40'hAA01000001, 5, 1'b1);
        push_pkt(40'hAA025AA5FD, 5, 1'b1);
        pulse(3'b001, 1'b0, 18'h00000);
        repeat (20) @(posedge clk);
        pulse(3'b111, 1'b1, 18'h3FFFF);
        repeat (20) @(posedge clk);
        pulse(3'b010, 1'b0, 18'h05AA5);
        @(negedge clk);
        check("ovw_drop", 32'(dropped_count), 32'(1));
        wait_done(400, n);
        wait_done(400, n);
        check("ovw_drop_end", 32'(dropped_count), 32'(1));
        check_idle("after_ovw");

        // Reset mid-packet aborts; line stays quiet afterwards
        push_pkt(40'hAA00000000, 1, 1'b0);
        pulse(3'b011, 1'b1, 18'h21234);
        repeat (60) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_idle("abort");
        check("abort_done", 32'(pkt_done),      32'(0));
        check("abort_drop", 32'(dropped_count), 32'(0));
        #1 reset = 1'b0;
        quiet = 1'b1;
        repeat (300) begin
            @(negedge clk);
            quiet = quiet & (uart_tx === 1'b1) & (busy === 1'b0) & (pkt_done === 1'b0);
        end
        check("abort_quiet", 32'(quiet), 32'(1));

        // 300 consecutive frame_valid cycles: three identical packets, drop saturates
        push_pkt(40'hAA0900555C, 5, 1'b1);
        push_pkt(40'hAA0900555C, 5, 1'b1);
        push_pkt(40'hAA0900555C, 5, 1'b1);
        @(posedge clk); #1;
        direction       = 3'b001;
        orange_detected = 1'b1;
        orange_count    = 18'h00055;
        frame_valid     = 1'b1;
        repeat (300) @(posedge clk);
        #1 frame_valid = 1'b0;
        @(negedge clk);
        check("sat_drop", 32'(dropped_count), 32'(255));
        n = 0;
        while (busy === 1'b1 && n < 800) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
        check("sat_drop_end", 32'(dropped_count), 32'(255));
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
